// File: rtl/exp_ctrl_if.sv
// exp_ctrl_if: MEM-stage bundle between the pipeline datapath and exp_ctrl.
//   master : pipeline side; drives the MEM-stage instruction fields,
//            receives per-stage stall/flush and the redirect PC.
//   slave  : exp_ctrl side; consumes the MEM-stage fields, drives the
//            stall/flush controls and NewPC.
// Signals:
//   MemPC, MemEn, MemBrFlag, MemCtrlOp, MemDstAddr, MemGPRWE_,
//   MemExpCode, MemOut                          -> MEM-stage instruction
//   IFStall/IDStall/EXStall/MemStall            <- stage stalls
//   IFFlush/IDFlush/EXFlush/MemFlush            <- stage flushes
//   NewPC                                       <- redirect target
interface exp_ctrl_if;
  logic [29:0] MemPC;
  logic        MemEn;
  logic        MemBrFlag;
  logic [1:0]  MemCtrlOp;
  logic [4:0]  MemDstAddr;
  logic        MemGPRWE_;
  logic [2:0]  MemExpCode;
  logic [31:0] MemOut;

  logic        IFStall;
  logic        IDStall;
  logic        EXStall;
  logic        MemStall;
  logic        IFFlush;
  logic        IDFlush;
  logic        EXFlush;
  logic        MemFlush;
  logic [29:0] NewPC;

  modport master (
    output MemPC, MemEn, MemBrFlag, MemCtrlOp, MemDstAddr, MemGPRWE_,
           MemExpCode, MemOut,
    input  IFStall, IDStall, EXStall, MemStall,
           IFFlush, IDFlush, EXFlush, MemFlush, NewPC
  );

  modport slave (
    input  MemPC, MemEn, MemBrFlag, MemCtrlOp, MemDstAddr, MemGPRWE_,
           MemExpCode, MemOut,
    output IFStall, IDStall, EXStall, MemStall,
           IFFlush, IDFlush, EXFlush, MemFlush, NewPC
  );
endinterface

// File: rtl/exp_ctrl.sv
// exp_ctrl: pipeline control and exception unit at the consumer end of the
// EX/MEM register. Commits exceptions precisely in MEM, executes WRCR/EXRT,
// holds the control-register file and produces per-stage stall/flush.
// Ports:
//   clk, reset_   clock, asynchronous active-low reset
//   bus           exp_ctrl_if.slave: MEM-stage fields in, stall/flush/NewPC out
//   IFBusy/MemBusy bus-access stall requests
//   LoadHazard    ID-stage load-use hazard
//   IRQ           level interrupt requests
//   CRAddr        CR read index from ID; CRRdData is the combinational result
//   IntDetect     registered unmasked-interrupt pending flag
//   ExeMode       current execution mode (0 kernel, 1 user)
module exp_ctrl #(
  parameter logic [29:0] EXP_VECTOR_RST = 30'h0
) (
  input  logic        clk,
  input  logic        reset_,
  exp_ctrl_if.slave   bus,
  input  logic        IFBusy,
  input  logic        MemBusy,
  input  logic        LoadHazard,
  input  logic [7:0]  IRQ,
  input  logic [4:0]  CRAddr,
  output logic [31:0] CRRdData,
  output logic        IntDetect,
  output logic        ExeMode
);

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  logic        mode;
  logic        ie;
  logic        pre_mode;
  logic        pre_ie;
  logic [29:0] epc;
  logic [29:0] exp_vector;
  logic        cause_dly;
  logic [2:0]  cause_code;
  logic [7:0]  int_mask;
  logic        int_detect;

  logic        busy;
  logic        exp_pending;
  logic        commit_exp;
  logic        commit_exrt;
  logic        commit_wrcr;
  logic [31:0] wr_data;
  logic [29:0] epc_next;

  // GPR write enable is carried through the interface but has no role here.
  logic unused_gprwe;
  assign unused_gprwe = bus.MemGPRWE_;

  // Commit qualification; a busy bus defers everything, and MemEn gates
  // both the exception code and the control op.
  assign busy        = IFBusy | MemBusy;
  assign exp_pending = bus.MemEn && (bus.MemExpCode != 3'd0);
  assign commit_exp  = !busy && exp_pending;
  assign commit_exrt = !busy && bus.MemEn && (bus.MemExpCode == 3'd0) &&
                       (bus.MemCtrlOp == OP_EXRT);
  assign commit_wrcr = !busy && bus.MemEn && (bus.MemExpCode == 3'd0) &&
                       (bus.MemCtrlOp == OP_WRCR);

  // A faulting delay-slot instruction restarts at its branch, one word back.
  assign epc_next = bus.MemBrFlag ? (bus.MemPC - 30'd1) : bus.MemPC;

  // Write data as the target register will actually hold it; shared by the
  // register update and the same-cycle read bypass.
  always_comb begin
    wr_data = '0;
    case (bus.MemDstAddr)
      5'd0, 5'd1: wr_data = {30'b0, bus.MemOut[1:0]};
      5'd2, 5'd3: wr_data = {bus.MemOut[31:2], 2'b00};
      5'd4:       wr_data = {28'b0, bus.MemOut[3:0]};
      5'd5:       wr_data = {24'b0, bus.MemOut[7:0]};
      default:    wr_data = '0;
    endcase
  end

  // Control-register state plus the registered interrupt detect.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mode       <= 1'b0;
      ie         <= 1'b0;
      pre_mode   <= 1'b0;
      pre_ie     <= 1'b0;
      epc        <= '0;
      exp_vector <= EXP_VECTOR_RST;
      cause_dly  <= 1'b0;
      cause_code <= '0;
      int_mask   <= 8'hFF;
      int_detect <= 1'b0;
    end else begin
      int_detect <= ie & (|(IRQ & ~int_mask));
      if (commit_exp) begin
        pre_mode   <= mode;
        pre_ie     <= ie;
        mode       <= 1'b0;
        ie         <= 1'b0;
        epc        <= epc_next;
        cause_dly  <= bus.MemBrFlag;
        cause_code <= bus.MemExpCode;
      end else if (commit_exrt) begin
        mode <= pre_mode;
        ie   <= pre_ie;
      end else if (commit_wrcr) begin
        case (bus.MemDstAddr)
          5'd0: begin
            mode <= wr_data[0];
            ie   <= wr_data[1];
          end
          5'd1: begin
            pre_mode <= wr_data[0];
            pre_ie   <= wr_data[1];
          end
          5'd2: epc        <= wr_data[31:2];
          5'd3: exp_vector <= wr_data[31:2];
          5'd4: begin
            cause_dly  <= wr_data[3];
            cause_code <= wr_data[2:0];
          end
          5'd5: int_mask <= wr_data[7:0];
          default: ;
        endcase
      end
    end
  end

  // Stage control; priority is busy, exception, EXRT, then load hazard.
  always_comb begin
    bus.IFStall  = 1'b0;
    bus.IDStall  = 1'b0;
    bus.EXStall  = 1'b0;
    bus.MemStall = 1'b0;
    bus.IFFlush  = 1'b0;
    bus.IDFlush  = 1'b0;
    bus.EXFlush  = 1'b0;
    bus.MemFlush = 1'b0;
    bus.NewPC    = '0;
    if (busy) begin
      bus.IFStall  = 1'b1;
      bus.IDStall  = 1'b1;
      bus.EXStall  = 1'b1;
      bus.MemStall = 1'b1;
    end else if (commit_exp || commit_exrt) begin
      bus.IFFlush  = 1'b1;
      bus.IDFlush  = 1'b1;
      bus.EXFlush  = 1'b1;
      bus.MemFlush = 1'b1;
      bus.NewPC    = commit_exp ? exp_vector : epc;
    end else if (LoadHazard) begin
      bus.IFStall = 1'b1;
      bus.IDStall = 1'b1;
      bus.EXFlush = 1'b1;
    end
  end

  // CR read port; a WRCR committing to the addressed writable register is
  // forwarded so ID sees the new value without a one-cycle gap.
  always_comb begin
    CRRdData = '0;
    case (CRAddr)
      5'd0:    CRRdData = {30'b0, ie, mode};
      5'd1:    CRRdData = {30'b0, pre_ie, pre_mode};
      5'd2:    CRRdData = {epc, 2'b00};
      5'd3:    CRRdData = {exp_vector, 2'b00};
      5'd4:    CRRdData = {28'b0, cause_dly, cause_code};
      5'd5:    CRRdData = {24'b0, int_mask};
      5'd6:    CRRdData = {24'b0, IRQ};
      default: CRRdData = '0;
    endcase
    if (commit_wrcr && (bus.MemDstAddr == CRAddr) && (CRAddr <= 5'd5))
      CRRdData = wr_data;
  end

  assign IntDetect = int_detect;
  assign ExeMode   = mode;

endmodule

// File: doc/exp_ctrl.md
Name: exp_ctrl

Overview:
- Pipeline control and exception unit. It is the consumer end of the EX/MEM pipeline register.
- Takes the MEM-stage outputs (PC, valid, branch flag, control op, destination, exception code, result) and the stage busy/hazard requests.
- Drives per-stage Stall/Flush, the redirect PC and the control-register (CR) file.
- Commits exceptions precisely at the MEM stage, and executes WRCR and EXRT.

Parameters:
- EXP_VECTOR_RST, 30'h0, reset value of CR3, the exception vector word address.

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- MemPC  in  30  word address of the MEM-stage instruction
- MemEn  in  1  MEM-stage instruction valid
- MemBrFlag  in  1  MEM-stage instruction is in a branch delay slot
- MemCtrlOp  in  2  0=NOP, 1=WRCR, 2=EXRT
- MemDstAddr  in  5  CR index for WRCR
- MemGPRWE_  in  1  GPR write enable, active-low (pass-through only, unused here)
- MemExpCode  in  3  0=NO_EXP, 1=EXT_INT, 2=UNDEF_INSN, 3=OVERFLOW, 4=MISS_ALIGN, 5=TRAP, 6=PRV_VIO
- MemOut  in  32  WRCR write data
- IFBusy, MemBusy  in  1  bus-access stall requests
- LoadHazard  in  1  ID-stage load-use hazard
- IRQ  in  8  level interrupt requests
- CRAddr  in  5  CR read index from ID
- CRRdData  out  32  combinational CR read data
- IFStall, IDStall, EXStall, MemStall  out  1  stage stalls
- IFFlush, IDFlush, EXFlush, MemFlush  out  1  stage flushes
- NewPC  out  30  redirect target, valid when IFFlush=1
- IntDetect  out  1  unmasked interrupt pending
- ExeMode  out  1  0=kernel, 1=user

Behaviour:
- CR map:
  - 0 STATUS {30'b0, IE, Mode}
  - 1 PRE_STATUS, same layout
  - 2 EPC {MemPC, 2'b0}
  - 3 EXP_VECTOR {vector, 2'b0}
  - 4 CAUSE {DlyFlag in bit 3, ExpCode in bits 2:0}
  - 5 INT_MASK in bits 7:0, 1 = masked
  - 6 IRQ, read-only, raw IRQ
  - 7–31 read as 0; writes to them are ignored
- Reset values:
  - Mode=0, IE=0, PRE_STATUS=0, EPC=0, EXP_VECTOR=EXP_VECTOR_RST, CAUSE=0, INT_MASK=8'hFF
  - All stall/flush outputs 0; NewPC=0
- Busy = IFBusy | MemBusy. When Busy=1:
  - all four Stall=1, all Flush=0
  - no CR update; exception/EXRT commit is deferred until Busy=0
- Exception (Busy=0, MemEn=1, MemExpCode≠0), same cycle:
  - all four Flush=1, Stall=0, NewPC=EXP_VECTOR
  - next clock: PRE_STATUS←STATUS; Mode←0; IE←0
  - EPC←MemBrFlag ? MemPC−1 : MemPC (30-bit wrap; 0−1 gives 30'h3FFFFFFF)
  - CAUSE←{MemBrFlag, MemExpCode}
- EXRT (Busy=0, MemEn=1, MemExpCode=0, MemCtrlOp=2):
  - all Flush=1, NewPC=EPC
  - next clock: STATUS←PRE_STATUS
- WRCR (Busy=0, MemEn=1, MemExpCode=0, MemCtrlOp=1):
  - write CR[MemDstAddr]←MemOut at the clock edge; no flush
  - For writes to CR0/1 only bits 1:0 are kept; for CR5 only bits 7:0.
  - CR2/CR3 store bits 31:2; bits 1:0 are ignored on write.
- LoadHazard (Busy=0, no exception/EXRT): IFStall=IDStall=1, EXFlush=1 (bubble), others 0.
- Priority: Busy > exception > EXRT > WRCR/LoadHazard. An exception overrides a concurrent LoadHazard.
- MemEn=0: MemCtrlOp and MemExpCode are ignored.
- IntDetect = IE & |(IRQ & ~INT_MASK). It is registered, so it asserts 1 cycle after the condition holds.
- CR read bypass: if a WRCR to CRAddr commits in the same cycle, CRRdData returns MemOut (masked per register).
- Asserting reset_ mid-operation clears all state immediately, without waiting for clk.

Test Plan:
- Reset: assert reset_ low mid-cycle → Stall/Flush=0, CRRdData(CR5)=32'hFF, CR3=0, ExeMode=0.
- Overflow: MemEn=1, MemExpCode=3, MemPC=30'h100, MemBrFlag=0, CR3 holds vector 30'h40 → all Flush=1, NewPC=30'h40; next cycle CR2=32'h400, CR4=32'h3, IE=0.
- Delay-slot miss-align: MemPC=30'h200, MemBrFlag=1, MemExpCode=4 → CR2=32'h7FC (MemPC−1 in bits 31:2), CR4=32'hC. MemPC=0 with MemBrFlag=1 → CR2=32'hFFFFFFFC.
- WRCR then EXRT:
  - WRCR CR1=32'h3 → read CR1=32'h3 (bypass the same cycle).
  - EXRT with EPC=30'h10 → NewPC=30'h10, flush all; next cycle ExeMode=1, IE=1.
- Busy vs exception: MemBusy=1 for 3 cycles with exception pending → all Stall=1, no flush, CR unchanged; on cycle 4 → flush, NewPC=EXP_VECTOR.
- Interrupt/hazard:
  - IE=1, INT_MASK=8'hFE, IRQ=8'h01 → IntDetect=1 next cycle.
  - IRQ=8'h02 → IntDetect stays 0.
  - LoadHazard=1 → IFStall=IDStall=1, EXFlush=1.
